// File: rtl/serial_pkg.sv
// Shared definitions for the serial link blocks (serialin / serialout).
// Holds the data width of one serial frame and the receiver/transmitter
// state type, so both ends of the link agree on them.
package serial_pkg;

    // Bits per serial frame (one byte, sent LSB first).
    localparam int SER_DATA_W = 8;

    // IDLE: no bits of the current frame seen yet.
    // SHIFT: between 1 and SER_DATA_W-1 bits collected.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/serialin_if.sv
// Bus bundle between a serial receiver and its surroundings.
//   sclk, sdata : serial clock/data from the transmitter (async to clk)
//   data_out    : received byte
//   valid/ready : byte handshake, transfer when both are high
//   overrun     : sticky, a completed byte was dropped
//   frame_err   : one-cycle pulse, partial frame discarded by timeout
// Modports: slave = receiver side, master = transmitter/consumer side.
interface serialin_if;
    import serial_pkg::*;

    logic                  sclk;
    logic                  sdata;
    logic [SER_DATA_W-1:0] data_out;
    logic                  valid;
    logic                  ready;
    logic                  overrun;
    logic                  frame_err;

    modport slave (
        input  sclk, sdata, ready,
        output data_out, valid, overrun, frame_err
    );

    modport master (
        output sclk, sdata, ready,
        input  data_out, valid, overrun, frame_err
    );

endinterface

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for one asynchronous bit.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears every stage to 0
//   d   : asynchronous input
//   q   : synchronized output, STAGES clk cycles behind d
// STAGES must be at least 2 (checked by the instantiating block).
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the value from before the edge, giving a true shift chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/serialin.sv
// Serial-to-parallel receiver for the serialout link.
// sclk and sdata are synchronized into clk, a falling sclk edge samples
// sdata, and 8 bits (LSB first) form a byte presented on a valid/ready
// handshake.
//   clk : system clock, all logic on its rising edge
//   rst : asynchronous active-high reset
//   bus : serialin_if.slave (sclk, sdata, ready in; data_out, valid,
//         overrun, frame_err out)
// Optional feature: define SERIALIN_TIMEOUT_EN to discard a partial frame
// after TIMEOUT_CYCLES clk cycles without an sclk falling edge; without it
// frame_err is tied low and a partial frame waits indefinitely.
module serialin
    import serial_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int SYNC_STAGES    = 2
) (
    input logic       clk,
    input logic       rst,
    serialin_if.slave bus
);

    if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("serialin: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    localparam logic [2:0] LAST_BIT = 3'(SER_DATA_W - 1);

    logic                  sclk_s;
    logic                  sdata_s;
    logic                  sclk_prev;
    logic                  fall;
    logic                  timeout_hit;
    logic                  byte_done;
    logic                  handshake;
    ser_state_t            state;
    ser_state_t            state_next;
    logic [2:0]            bit_cnt;
    logic [2:0]            bit_cnt_next;
    logic [SER_DATA_W-1:0] shreg;
    logic [SER_DATA_W-1:0] data_q;
    logic                  valid_q;
    logic                  overrun_q;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk (clk),
        .rst (rst),
        .d   (bus.sclk),
        .q   (sclk_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sdata (
        .clk (clk),
        .rst (rst),
        .d   (bus.sdata),
        .q   (sdata_s)
    );

    // Falling edge of the synchronized serial clock; at most one per cycle.
    assign fall      = sclk_prev & ~sclk_s;
    assign handshake = valid_q & bus.ready;

    // Frame FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
        end else begin
            state   <= state_next;
            bit_cnt <= bit_cnt_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        byte_done    = 1'b0;
        if (timeout_hit) begin
            state_next   = IDLE;
            bit_cnt_next = '0;
        end
        if (fall) begin
            if (timeout_hit || state == IDLE) begin
                // An edge coinciding with a timeout starts a fresh frame.
                state_next   = SHIFT;
                bit_cnt_next = 3'd1;
            end else if (bit_cnt == LAST_BIT) begin
                state_next   = IDLE;
                bit_cnt_next = '0;
                byte_done    = 1'b1;
            end else begin
                bit_cnt_next = bit_cnt + 3'd1;
            end
        end
    end

    // Shift register and output byte holding stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_prev <= 1'b0;
            shreg     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sclk_prev <= sclk_s;
            if (fall) begin
                shreg <= {sdata_s, shreg[SER_DATA_W-1:1]};
            end
            // A completed byte loads only into an empty or draining slot.
            if (byte_done && (!valid_q || handshake)) begin
                data_q  <= {sdata_s, shreg[SER_DATA_W-1:1]};
                valid_q <= 1'b1;
            end else if (handshake) begin
                valid_q <= 1'b0;
            end
            if (byte_done && valid_q && !handshake) begin
                overrun_q <= 1'b1;
            end else if (handshake) begin
                overrun_q <= 1'b0;
            end
        end
    end

`ifdef SERIALIN_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;
    logic            frame_err_q;

    assign timeout_hit = (state == SHIFT) && (to_cnt == TO_W'(TIMEOUT_CYCLES));

    // Idle-time counter: cleared by any edge and outside SHIFT, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= timeout_hit;
            if (fall || state != SHIFT) begin
                to_cnt <= '0;
            end else if (!timeout_hit) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

    assign bus.frame_err = frame_err_q;
`else
    assign timeout_hit   = 1'b0;
    assign bus.frame_err = 1'b0;
`endif

    assign bus.data_out = data_q;
    assign bus.valid    = valid_q;
    assign bus.overrun  = overrun_q;

endmodule

// File: doc/serialin.md
SERIALIN -- requirements
Module: serialin

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning clk cycles without an sclk falling edge before a partial frame is discarded.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth on sclk and sdata (minimum 2).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port sclk  input  1  serial clock from a serialout transmitter; idle low, asynchronous to clk.
REQ-006 SHALL have port sdata  input  1  serial data; changes on sclk rising edge, LSB first.
REQ-007 SHALL have port data_out  output  8  received byte.
REQ-008 SHALL have port valid  output  1  data_out holds an unconsumed byte.
REQ-009 SHALL have port ready  input  1  consumer accepts the byte when valid && ready.
REQ-010 SHALL have port overrun  output  1  sticky flag: a completed byte was dropped.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse: partial frame discarded by timeout.

Function
REQ-012 SHALL pass sclk and sdata through SYNC_STAGES flops each before any use.
REQ-013 SHALL detect an sclk falling edge as previous synchronized sclk = 1 and current = 0, at most one edge per clk cycle.
REQ-014 SHALL sample synchronized sdata in the edge cycle: shift register shifts right, new bit enters bit 7; after 8 bits, bit 0 = first bit received.
REQ-015 SHALL use a 3-bit bit counter and states IDLE (no bits) and SHIFT (1-7 bits); IDLE->SHIFT on first edge, SHIFT->IDLE on 8th edge or timeout.
REQ-016 SHALL, on the 8th edge, load the byte into data_out and assert valid on the next clk rising edge (1-cycle latency from edge detect).
REQ-017 SHALL hold data_out and valid stable until valid && ready; valid deasserts the cycle after the handshake unless a new byte loads.
REQ-018 SHALL, when a byte completes while valid=1 and ready=0, discard the new byte, keep data_out, and set overrun.
REQ-019 SHALL, when a byte completes in the same cycle as a handshake, load the new byte and keep valid=1 with no overrun.
REQ-020 SHALL clear overrun on the cycle after a handshake unless an overrun occurs in that same cycle (set wins).
REQ-021 SHALL restart the bit counter from 0 after every completed byte; back-to-back frames need no gap.

Reset
REQ-022 SHALL, while rst=1, force data_out=0, valid=0, overrun=0, frame_err=0, state IDLE, bit counter 0, timeout counter 0, synchronizer flops 0.
REQ-023 SHALL discard any partial frame on reset mid-frame; first edge after reset release is bit 0.

Configuration
REQ-024 SHALL compile the timeout only when SERIALIN_TIMEOUT_EN is defined: counter clears on every detected edge, counts in SHIFT, saturates at TIMEOUT_CYCLES.
REQ-025 SHALL, when the count reaches TIMEOUT_CYCLES, return to IDLE, clear the bit counter, and pulse frame_err for one cycle; an edge in that same cycle is treated as bit 0 of a new frame.
REQ-026 SHALL, without SERIALIN_TIMEOUT_EN, omit the counter, tie frame_err to 0, and keep SHIFT until 8 edges arrive.

Structure
REQ-027 SHALL take SER_DATA_W (8) and the IDLE/SHIFT state type from shared package serial_pkg, also used by serialout.
REQ-028 SHALL implement the synchronizer as sub-module sync_ff (parameter STAGES, 1-bit, async active-high reset to 0), instantiated twice.

Verification
REQ-029 SHALL cover single byte: 0xA5 sent LSB first, 2048-clk bit period, ready=1 -> valid for 1 cycle, data_out=0xA5, overrun=0.
REQ-030 SHALL cover backpressure: 0x3C then 0x81 with ready=0 -> data_out stays 0x3C, overrun=1 after the 2nd byte; ready=1 -> handshake, overrun clears next cycle.
REQ-031 SHALL cover simultaneous completion and handshake: 0x11 pending, ready pulsed in 0x22's completion cycle -> data_out=0x22, valid=1, overrun=0.
REQ-032 SHALL cover timeout (macro on, TIMEOUT_CYCLES=64): 3 bits then silence for 64 clks -> one frame_err pulse; next full frame 0x5A received correctly.
REQ-033 SHALL cover reset mid-frame: rst after 5 bits, then full 0xF0 -> data_out=0xF0, with no valid before the 8th new edge.
REQ-034 SHALL cover macro off: same stimulus as REQ-032 -> frame_err stays 0, the next 5 edges complete a byte from the 3 stale and 5 new bits.
